// File: rtl/debug_stream_pkg.sv
// Shared definitions for the debug frame streamer: FSM state encoding and
// the ASCII constants used to build a telemetry text line.
package debug_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DIGIT = 3'd2,
    SEP   = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational conversion of one 4-bit value to its uppercase ASCII hex
// character ('0'..'9', 'A'..'F').
module hex_nibble_to_ascii
  import debug_stream_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // Pick the digit or letter range, offset by the nibble value.
  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_ZERO + {4'b0000, i_nibble};
    end else begin
      o_ascii = ASCII_A + {4'b0000, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/debug_frame_streamer.sv
// Telemetry serializer: snapshots the enabled debug channels on a start
// request and streams them as one uppercase hex text line (channels separated
// by SEPARATOR, terminated by CR LF) over a byte valid/ready handshake.
module debug_frame_streamer
  import debug_stream_pkg::*;
#(
  parameter int         NUM_CHANNELS  = 4,
  parameter int         CHANNEL_BYTES = 2,
  parameter int         PERIOD_CYCLES = 1_200_000,
  parameter logic [7:0] SEPARATOR     = 8'h20
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_CHANNELS*CHANNEL_BYTES*8-1:0] channel_data,
  input  logic [NUM_CHANNELS-1:0]               channel_enable,
  input  logic                                  mode,
  input  logic                                  trigger,
  output logic [7:0]                            tx_byte,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic                                  busy,
  output logic [15:0]                           frame_count,
  output logic                                  overrun
);

  localparam int DATA_W  = NUM_CHANNELS * CHANNEL_BYTES * 8;
  localparam int NIBBLES = CHANNEL_BYTES * 2;
  localparam int CHAN_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int NIB_W   = $clog2(NIBBLES);
  localparam int PER_W   = $clog2(PERIOD_CYCLES);

  localparam logic [NIB_W-1:0] NIB_MSB  = NIB_W'(NIBBLES - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);

  // Priority encoder: index of the lowest set bit (0 when none is set).
  function automatic logic [CHAN_W-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CHAN_W'(i);
    end
  endfunction

  state_e                 r_state;
  state_e                 w_state_next;
  logic [DATA_W-1:0]      r_snap_data;
  logic [NUM_CHANNELS-1:0] r_snap_en;
  logic [CHAN_W-1:0]      r_chan;
  logic [NIB_W-1:0]       r_nib;
  logic [PER_W-1:0]       r_period;
  logic [15:0]            r_frame_count;
  logic                   r_overrun;

  logic                   w_start;
  logic                   w_begin;
  logic                   w_handshake;
  logic                   w_tx_valid;
  logic [7:0]             w_tx_byte;
  logic [NUM_CHANNELS-1:0] w_above;
  logic                   w_has_next;
  logic [CHAN_W-1:0]      w_next_chan;
  logic [3:0]             w_nibble;
  logic [7:0]             w_ascii;

  // Periodic requests come from the free-running counter, triggered ones
  // straight from the trigger pin; the unused source is ignored.
  assign w_start     = mode ? trigger : (r_period == PER_LAST);
  assign w_begin     = (r_state == IDLE) && w_start && (|channel_enable);
  assign w_handshake = w_tx_valid && tx_ready;

  // Snapshot enables strictly above the current channel, then pick the lowest.
  always_comb begin
    w_above = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_above[i] = r_snap_en[i] && (i > int'(r_chan));
    end
  end

  assign w_has_next  = |w_above;
  assign w_next_chan = lowest_set(w_above);

  // Select the nibble addressed by the channel and nibble pointers.
  always_comb begin
    w_nibble = r_snap_data[int'(r_chan) * CHANNEL_BYTES * 8 + int'(r_nib) * 4 +: 4];
  end

  hex_nibble_to_ascii u_hex (
    .i_nibble (w_nibble),
    .o_ascii  (w_ascii)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and the byte presented to the UART.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    w_state_next = r_state;
    w_tx_valid   = 1'b0;
    w_tx_byte    = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (w_start && (|channel_enable)) w_state_next = LOAD;
      end
      LOAD: begin
        w_state_next = DIGIT;
      end
      DIGIT: begin
        w_tx_valid = 1'b1;
        w_tx_byte  = w_ascii;
        if (tx_ready && (r_nib == '0)) begin
          w_state_next = w_has_next ? SEP : CR;
        end
      end
      SEP: begin
        w_tx_valid = 1'b1;
        w_tx_byte  = SEPARATOR;
        if (tx_ready) w_state_next = DIGIT;
      end
      CR: begin
        w_tx_valid = 1'b1;
        w_tx_byte  = ASCII_CR;
        if (tx_ready) w_state_next = LF;
      end
      LF: begin
        w_tx_valid = 1'b1;
        w_tx_byte  = ASCII_LF;
        if (tx_ready) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: period counter, snapshots, pointers, frame counter, overrun.
  always_ff @(posedge clk) begin
    // NOTE: snapshot registers are cleared on reset so a fresh frame never
    // depends on stale data; they are plain flops, not a memory array.
    if (!reset_n) begin
      r_period      <= '0;
      r_overrun     <= 1'b0;
      r_snap_data   <= '0;
      r_snap_en     <= '0;
      r_chan        <= '0;
      r_nib         <= '0;
      r_frame_count <= '0;
    end else begin
      r_period  <= (r_period == PER_LAST) ? '0 : r_period + 1'b1;
      r_overrun <= w_start && (r_state != IDLE);

      if (w_begin) begin
        r_snap_data <= channel_data;
        r_snap_en   <= channel_enable;
        r_chan      <= lowest_set(channel_enable);
        r_nib       <= NIB_MSB;
      end

      if (r_state == DIGIT && w_handshake && r_nib != '0) begin
        r_nib <= r_nib - 1'b1;
      end

      if (r_state == SEP && w_handshake) begin
        r_chan <= w_next_chan;
        r_nib  <= NIB_MSB;
      end

      if (r_state == LF && w_handshake) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign tx_valid    = w_tx_valid;
  assign tx_byte     = w_tx_byte;
  assign busy        = (r_state != IDLE);
  assign frame_count = r_frame_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_debug_frame_streamer.sv
// Self-checking bench for debug_frame_streamer: table-driven triggered frames
// plus hand-written stall, overrun, reset and periodic-mode sequences.
module tb_debug_frame_streamer;

  localparam int NC = 2;
  localparam int CB = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] channel_data;
  logic [1:0]  channel_enable;
  logic        mode;
  logic        trigger;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] frame_count;
  logic        overrun;

  always #5 clk = ~clk;

  debug_frame_streamer #(
    .NUM_CHANNELS  (NC),
    .CHANNEL_BYTES (CB),
    .PERIOD_CYCLES (20),
    .SEPARATOR     (8'h20)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .channel_data   (channel_data),
    .channel_enable (channel_enable),
    .mode           (mode),
    .trigger        (trigger),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .frame_count    (frame_count),
    .overrun        (overrun)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  en;
    int          len;
    logic [87:0] bytes;   // expected characters, first one in the top byte
  } vec_t;

  vec_t       vecs[5];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q_bytes[$];
  int         done_at;
  int         exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    if (tx_valid && tx_ready) q_bytes.push_back(tx_byte);
  endtask

  // Observe until busy drops; optional random back-pressure and a mid-frame
  // change of the live channel inputs at cycle change_at.
  task automatic run_frame(input int max_cycles, input bit rand_ready,
                           input int change_at, input bit keep);
    logic [7:0] prev_byte;
    bit         prev_stall;
    if (!keep) q_bytes.delete();
    done_at    = -1;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    for (int c = 0; c < max_cycles; c++) begin
      step();
      if (prev_stall) begin
        check("stall_hold_valid", {31'b0, tx_valid}, 32'd1);
        check("stall_hold_byte", {24'b0, tx_byte}, {24'b0, prev_byte});
      end
      if (!busy) begin
        done_at = c;
        break;
      end
      if (rand_ready) tx_ready = ($urandom_range(0, 1) == 1);
      obs();
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      if (c == change_at) begin
        channel_data   = 32'h5A5A_F00F;
        channel_enable = 2'b01;
      end
    end
    tx_ready = 1'b1;
    if (done_at < 0) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_bytes(input string tag, input int v);
    check({tag, "_len"}, q_bytes.size(), vecs[v].len);
    for (int i = 0; i < vecs[v].len; i++) begin
      if (i < q_bytes.size()) begin
        check($sformatf("%s_byte%0d", tag, i), {24'b0, q_bytes[i]},
              {24'b0, vecs[v].bytes[87 - 8*i -: 8]});
      end
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int starts[$];
    bit prev_busy;
    int ovr_seen;

    vecs[0] = '{32'hABCD_0123, 2'b11, 11, 88'h30_31_32_33_20_41_42_43_44_0D_0A};
    vecs[1] = '{32'hABCD_0123, 2'b10,  6, 88'h41_42_43_44_0D_0A_00_00_00_00_00};
    vecs[2] = '{32'hABCD_0123, 2'b01,  6, 88'h30_31_32_33_0D_0A_00_00_00_00_00};
    vecs[3] = '{32'h00FF_9E5A, 2'b11, 11, 88'h39_45_35_41_20_30_30_46_46_0D_0A};
    vecs[4] = '{32'hABCD_0123, 2'b00,  0, 88'h0};

    reset_n        = 1'b0;
    channel_data   = '0;
    channel_enable = '0;
    mode           = 1'b1;
    trigger        = 1'b0;
    tx_ready       = 1'b1;
    step();
    step();
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("rst_frame_count", {16'b0, frame_count}, 32'd0);
    reset_n = 1'b1;
    step();

    // Table-driven triggered frames.
    exp_count = 0;
    for (int v = 0; v < 5; v++) begin
      channel_data   = vecs[v].data;
      channel_enable = vecs[v].en;
      pulse_trigger();
      check($sformatf("v%0d_busy_at_load", v), {31'b0, busy}, (vecs[v].len != 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_valid_at_load", v), {31'b0, tx_valid}, 32'd0);
      if (vecs[v].len != 0) begin
        run_frame(40, 1'b0, -1, 1'b0);
        compare_bytes($sformatf("v%0d", v), v);
        check($sformatf("v%0d_done_cycle", v), done_at, vecs[v].len);
        exp_count++;
      end else begin
        seen = 0;
        for (int c = 0; c < 10; c++) begin
          step();
          if (tx_valid || busy || overrun) seen++;
        end
        check($sformatf("v%0d_no_output", v), seen, 32'd0);
      end
      check($sformatf("v%0d_frame_count", v), {16'b0, frame_count}, exp_count);
    end

    // Random back-pressure with live inputs changed mid-frame.
    channel_data   = vecs[0].data;
    channel_enable = vecs[0].en;
    pulse_trigger();
    run_frame(300, 1'b1, 3, 1'b0);
    compare_bytes("stall", 0);
    exp_count++;
    check("stall_frame_count", {16'b0, frame_count}, exp_count);

    // Second trigger three cycles after the first is dropped with overrun.
    channel_data   = vecs[0].data;
    channel_enable = vecs[0].en;
    q_bytes.delete();
    pulse_trigger();
    obs();
    check("ovr_first_none", {31'b0, overrun}, 32'd0);
    step(); obs();
    step(); obs();
    pulse_trigger();
    check("ovr_pulse", {31'b0, overrun}, 32'd1);
    obs();
    step();
    check("ovr_pulse_end", {31'b0, overrun}, 32'd0);
    obs();
    run_frame(40, 1'b0, -1, 1'b1);
    compare_bytes("ovr", 0);
    exp_count++;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy || tx_valid) seen++;
    end
    check("ovr_single_frame", seen, 32'd0);
    check("ovr_frame_count", {16'b0, frame_count}, exp_count);

    // Reset while the 4th character is on the bus.
    q_bytes.delete();
    pulse_trigger();
    for (int c = 0; c < 10; c++) begin
      step();
      if (q_bytes.size() == 3 && tx_valid) break;
      obs();
    end
    check("mid_rst_pos", {24'b0, tx_byte}, 32'h33);
    reset_n = 1'b0;
    step();
    check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_overrun", {31'b0, overrun}, 32'd0);
    check("mid_rst_byte", {24'b0, tx_byte}, 32'd0);
    check("mid_rst_count", {16'b0, frame_count}, 32'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (tx_valid) seen++;
    end
    check("mid_rst_no_crlf", seen, 32'd0);
    pulse_trigger();
    run_frame(40, 1'b0, -1, 1'b0);
    compare_bytes("post_rst", 0);
    check("post_rst_count", {16'b0, frame_count}, 32'd1);

    // Periodic mode: starts every 20 cycles, trigger ignored.
    reset_n = 1'b0;
    mode    = 1'b0;
    step();
    step();
    reset_n   = 1'b1;
    prev_busy = 1'b0;
    ovr_seen  = 0;
    starts.delete();
    for (int c = 0; c < 115; c++) begin
      step();
      if (busy && !prev_busy) starts.push_back(c);
      if (overrun) ovr_seen++;
      prev_busy = busy;
      trigger   = (c == 4);
    end
    trigger = 1'b0;
    check("per_num_starts", starts.size(), 32'd5);
    if (starts.size() > 0) check("per_first_start", starts[0], 32'd19);
    for (int i = 1; i < starts.size(); i++) begin
      check($sformatf("per_spacing%0d", i), starts[i] - starts[i-1], 32'd20);
    end
    check("per_no_overrun", ovr_seen, 32'd0);
    check("per_frame_count", {16'b0, frame_count}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
